// File: rtl/dm_port_scheduler_if.sv
// Bundle of load, store-buffer, fence and data-memory signals around dm_port_scheduler.
// master: the surrounding LSU/commit logic plus DM macro (drives requests, DM_rd_data).
// slave : the scheduler (drives grants, responses, buffer status and the DM controls).
interface dm_port_scheduler_if #(
  parameter int SB_DEPTH = 4
) ();
  logic                       ld_req_valid;
  logic [31:0]                ld_req_addr;
  logic                       ld_req_ready;
  logic                       ld_rsp_valid;
  logic [31:0]                ld_rsp_data;
  logic                       st_in_valid;
  logic [31:0]                st_in_addr;
  logic [31:0]                st_in_wdata;
  logic [31:0]                st_in_wmask;
  logic                       st_in_ready;
  logic                       drain_all;
  logic                       fence_done;
  logic [$clog2(SB_DEPTH):0]  sb_count;
  logic                       DM_r_en;
  logic [31:0]                DM_w_en;
  logic [31:0]                DM_addr;
  logic [31:0]                DM_w_data;
  logic [31:0]                DM_rd_data;

  modport master (
    output ld_req_valid, ld_req_addr, st_in_valid, st_in_addr, st_in_wdata,
           st_in_wmask, drain_all, DM_rd_data,
    input  ld_req_ready, ld_rsp_valid, ld_rsp_data, st_in_ready, fence_done,
           sb_count, DM_r_en, DM_w_en, DM_addr, DM_w_data
  );

  modport slave (
    input  ld_req_valid, ld_req_addr, st_in_valid, st_in_addr, st_in_wdata,
           st_in_wmask, drain_all, DM_rd_data,
    output ld_req_ready, ld_rsp_valid, ld_rsp_data, st_in_ready, fence_done,
           sb_count, DM_r_en, DM_w_en, DM_addr, DM_w_data
  );
endinterface

// File: rtl/dm_port_scheduler.sv
// Purpose: arbitrates the single DM port between load reads and a posted committed-store FIFO.
// Latency: load granted combinationally, data returned one cycle after grant; stores drain when idle/forced.
// Backpressure: ld_req_ready drops on drain/hazard/fence; st_in_ready drops when the buffer is full.
// Ports: clk, rst (async active-low), bus (slave modport: load req/rsp, store push,
//        fence request/done, sb_count, DM read/write controls and DM_rd_data).
module dm_port_scheduler #(
  parameter int SB_DEPTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  dm_port_scheduler_if.slave bus
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = $clog2(SB_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL       = CW'(SB_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
  } sb_entry_t;

  typedef enum logic {NORMAL, FENCE} state_t;

  sb_entry_t           mem [SB_DEPTH];
  logic [SB_DEPTH-1:0] vld;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;
  logic [CW-1:0]       cnt_nxt;
  logic [SW-1:0]       starve_cnt;
  state_t              state;
  state_t              state_nxt;
  logic                fence_empty_q;
  logic                fence_empty_nxt;
  logic                fence_last;
  logic                rsp_vld_q;

  logic push;
  logic pop;
  logic sb_hit;
  logic hz;
  logic drain;
  logic grant;

  // Word-granular match of the load against every live buffer entry.
  always_comb begin
    sb_hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (vld[i] && (mem[i].addr[31:2] == bus.ld_req_addr[31:2])) begin
        sb_hit = 1'b1;
      end
    end
  end

  // A store committing this very cycle also blocks a same-word load, so the
  // load always observes it once it has drained.
  assign hz = bus.ld_req_valid &&
              (sb_hit || (bus.st_in_valid &&
                          (bus.st_in_addr[31:2] == bus.ld_req_addr[31:2])));

  assign bus.st_in_ready = (count != FULL);
  assign push            = bus.st_in_valid && bus.st_in_ready;

  // count is registered, so an entry pushed into an empty buffer only becomes
  // drainable on the following cycle.
  assign drain = (count != '0) &&
                 ((state == FENCE) || (count == FULL) || !bus.ld_req_valid ||
                  hz || (starve_cnt == STARVE_MAX));
  assign pop   = drain;

  // rst gating keeps DM_r_en low while reset is asserted even if a load is pending.
  assign grant = rst && bus.ld_req_valid && !drain && !hz && (state == NORMAL);
  assign bus.ld_req_ready = grant;

  assign cnt_nxt = count + CW'(push) - CW'(pop);

  // DM port drive: write from head entry, read for a granted load, else idle.
  always_comb begin
    bus.DM_r_en   = 1'b0;
    bus.DM_w_en   = '1;
    bus.DM_addr   = '0;
    bus.DM_w_data = '0;
    if (drain) begin
      bus.DM_addr   = mem[head].addr;
      bus.DM_w_en   = mem[head].wmask;
      bus.DM_w_data = mem[head].wdata;
    end else if (grant) begin
      bus.DM_r_en   = 1'b1;
      bus.DM_addr   = bus.ld_req_addr;
    end
  end

  // Fence FSM. Emptiness is judged on the post-cycle occupancy so a fence that
  // lands on the last pop (or on an empty buffer with no push) completes
  // without entering FENCE and waiting forever.
  always_comb begin
    state_nxt       = state;
    fence_empty_nxt = 1'b0;
    fence_last      = 1'b0;
    case (state)
      NORMAL: begin
        if (bus.drain_all) begin
          if (cnt_nxt == '0) begin
            fence_empty_nxt = 1'b1;
          end else begin
            state_nxt = FENCE;
          end
        end
      end
      FENCE: begin
        // count is non-zero throughout FENCE, so reaching zero means a pop
        // with no simultaneous push.
        if (cnt_nxt == '0) begin
          state_nxt  = NORMAL;
          fence_last = 1'b1;
        end
      end
      default: state_nxt = NORMAL;
    endcase
  end

  assign bus.fence_done   = fence_empty_q | fence_last;
  assign bus.ld_rsp_valid = rsp_vld_q;
  assign bus.ld_rsp_data  = rsp_vld_q ? bus.DM_rd_data : '0;
  assign bus.sb_count     = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      vld           <= '0;
      state         <= NORMAL;
      starve_cnt    <= '0;
      rsp_vld_q     <= 1'b0;
      fence_empty_q <= 1'b0;
    end else begin
      if (push) begin
        tail      <= tail + PW'(1);
        vld[tail] <= 1'b1;
      end
      if (pop) begin
        head      <= head + PW'(1);
        vld[head] <= 1'b0;
      end
      count         <= cnt_nxt;
      state         <= state_nxt;
      fence_empty_q <= fence_empty_nxt;
      rsp_vld_q     <= grant;
      if (drain || (count == '0)) begin
        starve_cnt <= '0;
      end else if (grant && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

  // Entry payload needs no reset; liveness is tracked by vld/count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{addr: bus.st_in_addr, wdata: bus.st_in_wdata, wmask: bus.st_in_wmask};
    end
  end

endmodule

// File: tb/tb_dm_port_scheduler.sv
// Purpose: self-checking bench for dm_port_scheduler with a DM memory model and scoreboards.
// Latency: load data expected one cycle after grant; writes checked in FIFO order as they hit DM.
// Backpressure: exercises full buffer, starvation limit, word hazard, fences and mid-drain reset.
module tb_dm_port_scheduler;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
  } wr_t;

  logic clk;
  logic rst;

  dm_port_scheduler_if #(.SB_DEPTH(4)) bus ();

  dm_port_scheduler #(.SB_DEPTH(4), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] dm_mem  [256];
  logic [31:0] ref_mem [256];
  logic [31:0] ld_exp [$];
  wr_t         wr_exp [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, wanted %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // DM macro: registered read, per-bit active-low write enable.
  always @(posedge clk) begin
    if (bus.DM_r_en) begin
      bus.DM_rd_data <= dm_mem[bus.DM_addr[9:2]];
    end
    if (bus.DM_w_en != 32'hFFFF_FFFF) begin
      dm_mem[bus.DM_addr[9:2]] <= (dm_mem[bus.DM_addr[9:2]] & bus.DM_w_en) |
                                  (bus.DM_w_data & ~bus.DM_w_en);
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.ld_rsp_valid) begin
        chk("ld_rsp_pending", 32'(ld_exp.size() != 0), 32'd1);
        if (ld_exp.size() != 0) begin
          chk("ld_rsp_data", bus.ld_rsp_data, ld_exp.pop_front());
        end
      end
      if (bus.DM_w_en != 32'hFFFF_FFFF) begin
        chk("wr_pending", 32'(wr_exp.size() != 0), 32'd1);
        chk("wr_no_rd", 32'(bus.DM_r_en), 32'd0);
        if (wr_exp.size() != 0) begin
          wr_t e;
          e = wr_exp.pop_front();
          chk("wr_addr", bus.DM_addr, e.addr);
          chk("wr_data", bus.DM_w_data, e.data);
          chk("wr_mask", bus.DM_w_en, e.mask);
        end
      end
      if (bus.st_in_valid && bus.st_in_ready) begin
        wr_t e;
        e.addr = bus.st_in_addr;
        e.data = bus.st_in_wdata;
        e.mask = bus.st_in_wmask;
        wr_exp.push_back(e);
        ref_mem[bus.st_in_addr[9:2]] = (ref_mem[bus.st_in_addr[9:2]] & bus.st_in_wmask) |
                                       (bus.st_in_wdata & ~bus.st_in_wmask);
      end
      if (bus.ld_req_ready) begin
        ld_exp.push_back(ref_mem[bus.ld_req_addr[9:2]]);
      end
    end
  end

  task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    bus.st_in_valid = 1'b1;
    bus.st_in_addr  = a;
    bus.st_in_wdata = d;
    bus.st_in_wmask = m;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dm_mem[i]  = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    dm_mem[8'h40]  = 32'hDEAD_BEEF;
    ref_mem[8'h40] = 32'hDEAD_BEEF;

    rst              = 1'b0;
    bus.ld_req_valid = 1'b1;
    bus.ld_req_addr  = 32'h100;
    bus.st_in_valid  = 1'b0;
    bus.st_in_addr   = '0;
    bus.st_in_wdata  = '0;
    bus.st_in_wmask  = '1;
    bus.drain_all    = 1'b0;

    // Reset state, with a load already requesting.
    at_neg();
    chk("rst_r_en", 32'(bus.DM_r_en), 32'd0);
    chk("rst_w_en", bus.DM_w_en, 32'hFFFF_FFFF);
    chk("rst_addr", bus.DM_addr, 32'h0);
    chk("rst_wdata", bus.DM_w_data, 32'h0);
    chk("rst_rsp_vld", 32'(bus.ld_rsp_valid), 32'd0);
    chk("rst_fence_done", 32'(bus.fence_done), 32'd0);
    chk("rst_count", 32'(bus.sb_count), 32'd0);
    tick();
    rst = 1'b1;

    // Basic load.
    at_neg();
    chk("ld0_ready", 32'(bus.ld_req_ready), 32'd1);
    chk("ld0_r_en", 32'(bus.DM_r_en), 32'd1);
    chk("ld0_addr", bus.DM_addr, 32'h100);
    chk("ld0_w_en", bus.DM_w_en, 32'hFFFF_FFFF);
    tick();
    bus.ld_req_valid = 1'b0;
    at_neg();
    chk("ld0_rsp_vld", 32'(bus.ld_rsp_valid), 32'd1);
    chk("ld0_rsp_data", bus.ld_rsp_data, 32'hDEAD_BEEF);
    chk("ld0_rsp_w_en", bus.DM_w_en, 32'hFFFF_FFFF);
    tick();

    // Fill the buffer under continuous loads: full forces a drain, then the
    // starvation limit forces another after four grants.
    bus.ld_req_valid = 1'b1;
    bus.ld_req_addr  = 32'h200;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) push_st(32'h10 + 32'(4 * c), 32'h1111_0000 + 32'(c), 32'h0);
      else bus.st_in_valid = 1'b0;
      at_neg();
      chk($sformatf("starve_gnt_c%0d", c), 32'(bus.ld_req_ready), (c == 4 || c == 9) ? 32'd0 : 32'd1);
      if (c == 4) begin
        chk("full_st_ready", 32'(bus.st_in_ready), 32'd0);
        chk("full_count", 32'(bus.sb_count), 32'd4);
        chk("full_drain_addr", bus.DM_addr, 32'h10);
      end
      if (c == 9) chk("starve_drain_addr", bus.DM_addr, 32'h14);
      tick();
    end
    bus.ld_req_valid = 1'b0;
    at_neg();
    chk("idle_drain_addr0", bus.DM_addr, 32'h18);
    tick();
    at_neg();
    chk("idle_drain_addr1", bus.DM_addr, 32'h1C);
    tick();
    at_neg();
    chk("drained_count", 32'(bus.sb_count), 32'd0);
    chk("drained_w_en", bus.DM_w_en, 32'hFFFF_FFFF);
    tick();

    // Load-after-store hazard on the same word.
    push_st(32'h41, 32'h0000_CD00, 32'hFFFF_00FF);
    bus.ld_req_valid = 1'b1;
    bus.ld_req_addr  = 32'h40;
    at_neg();
    chk("hz_c0_ready", 32'(bus.ld_req_ready), 32'd0);
    chk("hz_c0_r_en", 32'(bus.DM_r_en), 32'd0);
    chk("hz_c0_w_en", bus.DM_w_en, 32'hFFFF_FFFF);
    tick();
    bus.st_in_valid = 1'b0;
    at_neg();
    chk("hz_c1_ready", 32'(bus.ld_req_ready), 32'd0);
    chk("hz_c1_w_en", bus.DM_w_en, 32'hFFFF_00FF);
    chk("hz_c1_addr", bus.DM_addr, 32'h41);
    chk("hz_c1_wdata", bus.DM_w_data, 32'h0000_CD00);
    tick();
    at_neg();
    chk("hz_c2_ready", 32'(bus.ld_req_ready), 32'd1);
    chk("hz_c2_addr", bus.DM_addr, 32'h40);
    tick();
    bus.ld_req_valid = 1'b0;
    at_neg();
    chk("hz_rsp_data", bus.ld_rsp_data, 32'hA500_CD10);
    tick();

    // Fence with three buffered stores and a load pending.
    bus.ld_req_valid = 1'b1;
    bus.ld_req_addr  = 32'h300;
    for (int c = 0; c < 3; c++) begin
      push_st(32'h80 + 32'(4 * c), 32'h2222_0000 + 32'(c), 32'h0);
      at_neg();
      chk($sformatf("fence_fill_gnt%0d", c), 32'(bus.ld_req_ready), 32'd1);
      tick();
    end
    bus.st_in_valid = 1'b0;
    bus.drain_all   = 1'b1;
    at_neg();
    chk("fence_req_gnt", 32'(bus.ld_req_ready), 32'd1);
    chk("fence_req_done", 32'(bus.fence_done), 32'd0);
    chk("fence_req_count", 32'(bus.sb_count), 32'd3);
    tick();
    bus.drain_all = 1'b0;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk($sformatf("fence_gnt%0d", k), 32'(bus.ld_req_ready), 32'd0);
      chk($sformatf("fence_addr%0d", k), bus.DM_addr, 32'h80 + 32'(4 * k));
      chk($sformatf("fence_done%0d", k), 32'(bus.fence_done), (k == 2) ? 32'd1 : 32'd0);
      tick();
    end
    at_neg();
    chk("fence_after_gnt", 32'(bus.ld_req_ready), 32'd1);
    chk("fence_after_done", 32'(bus.fence_done), 32'd0);
    chk("fence_after_count", 32'(bus.sb_count), 32'd0);
    tick();

    // Fence on an empty buffer.
    bus.ld_req_addr = 32'h104;
    bus.drain_all   = 1'b1;
    at_neg();
    chk("efence_c0_gnt", 32'(bus.ld_req_ready), 32'd1);
    chk("efence_c0_done", 32'(bus.fence_done), 32'd0);
    tick();
    bus.drain_all = 1'b0;
    at_neg();
    chk("efence_c1_gnt", 32'(bus.ld_req_ready), 32'd1);
    chk("efence_c1_done", 32'(bus.fence_done), 32'd1);
    tick();
    at_neg();
    chk("efence_c2_gnt", 32'(bus.ld_req_ready), 32'd1);
    chk("efence_c2_done", 32'(bus.fence_done), 32'd0);
    tick();

    // Reset in the middle of a drain with two entries buffered.
    bus.ld_req_addr = 32'h204;
    push_st(32'hC0, 32'h3333_0000, 32'h0);
    at_neg();
    tick();
    push_st(32'hC4, 32'h3333_0001, 32'h0);
    at_neg();
    tick();
    bus.st_in_valid  = 1'b0;
    bus.ld_req_valid = 1'b0;
    at_neg();
    chk("mid_count", 32'(bus.sb_count), 32'd2);
    chk("mid_w_en", bus.DM_w_en, 32'h0);
    #2;
    rst = 1'b0;
    wr_exp.delete();
    ld_exp.delete();
    #1;
    chk("arst_w_en", bus.DM_w_en, 32'hFFFF_FFFF);
    chk("arst_r_en", 32'(bus.DM_r_en), 32'd0);
    chk("arst_addr", bus.DM_addr, 32'h0);
    chk("arst_wdata", bus.DM_w_data, 32'h0);
    chk("arst_rsp_vld", 32'(bus.ld_rsp_valid), 32'd0);
    chk("arst_count", 32'(bus.sb_count), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      at_neg();
      chk($sformatf("post_rst_w_en%0d", c), bus.DM_w_en, 32'hFFFF_FFFF);
      chk($sformatf("post_rst_count%0d", c), 32'(bus.sb_count), 32'd0);
      tick();
    end

    // Plain load after reset recovery.
    bus.ld_req_valid = 1'b1;
    bus.ld_req_addr  = 32'h100;
    at_neg();
    chk("final_gnt", 32'(bus.ld_req_ready), 32'd1);
    tick();
    bus.ld_req_valid = 1'b0;
    at_neg();
    chk("final_rsp", bus.ld_rsp_data, 32'hDEAD_BEEF);
    tick();
    tick();

    chk("ld_q_empty", 32'(ld_exp.size()), 32'd0);
    chk("wr_q_empty", 32'(wr_exp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
